// File: rtl/dcm_sequencer_pkg.sv
// Shared definitions for the DCM lock/reset sequencer: FSM encoding,
// STATUS bit positions and counter sizing helpers.
package dcm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET_DCM = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_PS_WAIT   = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    // DCM_SP STATUS[2:0] bit positions.
    localparam int STATUS_PS_OVF     = 0;
    localparam int STATUS_CLKIN_STOP = 1;
    localparam int STATUS_CLKFX_STOP = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the largest of two cycle counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = max_int(a, b);
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dcm_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous DCM status signals.
module dcm_sequencer_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_sequencer.sv
// DCM_SP lock/reset sequencer with dynamic phase-shift control.
// Handshake: a phase-step request transfers on the clkin edge where
// ps_valid && ps_ready are both high; ps_ready is high only in RUN. If the
// DCM loses lock on that same edge the step is dropped, since the DCM is
// reset and the tracked phase is cleared anyway.
module dcm_sequencer
    import dcm_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_RETRIES   = 3,
    parameter int PS_LIMIT      = 255,
    parameter int PS_TIMEOUT    = 1023
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              dcm_locked,
    input  logic [2:0]        dcm_status,
    input  logic              dcm_psdone,
    output logic              dcm_rst,
    output logic              dcm_psen,
    output logic              dcm_psincdec,
    input  logic              ps_valid,
    input  logic              ps_dir,
    output logic              ps_ready,
    output logic signed [8:0] ps_value,
    output logic              ps_err,
    output logic              core_rst_n,
    output logic              ready,
    output logic              fail,
    output logic [1:0]        retry_count,
    output state_t            dbg_state
);

    localparam int CW = cnt_width(max_int(LOCK_TIMEOUT, PS_TIMEOUT),
                                  max_int(RST_CYCLES, SETTLE_CYCLES));

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] PS_LAST     = CW'(PS_TIMEOUT - 1);

    localparam logic signed [8:0] PS_MAX = 9'(PS_LIMIT);
    localparam logic signed [8:0] PS_MIN = -PS_MAX;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [1:0]        retry_d;
    logic [2:0]        retry_inc;
    logic signed [8:0] ps_value_d;
    logic              dcm_rst_d, psen_d, psincdec_d, ps_err_d;
    logic              ps_ready_d, ready_d, fail_d;
    logic              lk, bad, at_limit;
    logic [2:0]        status_s;
    logic              unused_status_ovf;

    dcm_sequencer_sync_2ff #(.WIDTH(1)) u_sync_locked (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (dcm_locked),
        .q     (lk)
    );

    dcm_sequencer_sync_2ff #(.WIDTH(3)) u_sync_status (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (dcm_status),
        .q     (status_s)
    );

    // Phase overflow is not used: the phase value saturates locally.
    assign unused_status_ovf = status_s[STATUS_PS_OVF];
    assign bad       = status_s[STATUS_CLKIN_STOP] | status_s[STATUS_CLKFX_STOP];
    assign retry_inc = {1'b0, retry_count} + 3'd1;
    assign at_limit  = ps_dir ? (ps_value == PS_MAX) : (ps_value == PS_MIN);
    assign dbg_state = state;

    // Next-state, counter and next-output computation.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        retry_d    = retry_count;
        ps_value_d = ps_value;
        psen_d     = 1'b0;
        psincdec_d = dcm_psincdec;
        ps_err_d   = 1'b0;
        case (state)
            ST_RESET_DCM: begin
                if (cnt == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt == LOCK_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_inc[1:0];
                    state_d = (int'(retry_inc) >= MAX_RETRIES) ? ST_FAIL : ST_RESET_DCM;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = 2'd0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lk || bad) begin
                    state_d = ST_RESET_DCM;
                    cnt_d   = '0;
                end else if (ps_valid && ps_ready) begin
                    if (at_limit) begin
                        ps_err_d = 1'b1;
                    end else begin
                        psen_d     = 1'b1;
                        psincdec_d = ps_dir;
                        state_d    = ST_PS_WAIT;
                        cnt_d      = '0;
                    end
                end
            end
            ST_PS_WAIT: begin
                if (!lk || bad) begin
                    state_d = ST_RESET_DCM;
                    cnt_d   = '0;
                end else if (dcm_psdone) begin
                    ps_value_d = dcm_psincdec ? (ps_value + 9'sd1) : (ps_value - 9'sd1);
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                end else if (cnt == PS_LAST) begin
                    state_d = ST_RESET_DCM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET_DCM;
                cnt_d   = '0;
            end
        endcase
        // Any new DCM reset abandons the tracked phase.
        if (state_d == ST_RESET_DCM && state != ST_RESET_DCM) begin
            ps_value_d = '0;
        end
        dcm_rst_d  = (state_d == ST_RESET_DCM) || (state_d == ST_FAIL);
        ready_d    = (state_d == ST_RUN) || (state_d == ST_PS_WAIT);
        ps_ready_d = (state_d == ST_RUN);
        fail_d     = (state_d == ST_FAIL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RESET_DCM;
            cnt          <= '0;
            retry_count  <= 2'd0;
            ps_value     <= '0;
            dcm_rst      <= 1'b1;
            dcm_psen     <= 1'b0;
            dcm_psincdec <= 1'b0;
            ps_err       <= 1'b0;
            ps_ready     <= 1'b0;
            core_rst_n   <= 1'b0;
            ready        <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            retry_count  <= retry_d;
            ps_value     <= ps_value_d;
            dcm_rst      <= dcm_rst_d;
            dcm_psen     <= psen_d;
            dcm_psincdec <= psincdec_d;
            ps_err       <= ps_err_d;
            ps_ready     <= ps_ready_d;
            core_rst_n   <= ready_d;
            ready        <= ready_d;
            fail         <= fail_d;
        end
    end

endmodule

// File: tb/tb_dcm_sequencer.sv
// Bench for dcm_sequencer: directed lock/phase/fault sequence with random
// step directions, PSDONE latencies and relock delays.
module tb_dcm_sequencer;
    import dcm_sequencer_pkg::*;

    localparam int RST_CYC  = 8;
    localparam int LOCK_TO  = 300;
    localparam int SETTLE   = 16;
    localparam int RETRIES  = 3;
    localparam int LIMIT    = 255;
    localparam int PS_TO    = 100;

    logic              clkin = 1'b0;
    logic              rst_n;
    logic              dcm_locked;
    logic [2:0]        dcm_status;
    logic              dcm_psdone;
    logic              dcm_rst, dcm_psen, dcm_psincdec;
    logic              ps_valid, ps_dir, ps_ready, ps_err;
    logic signed [8:0] ps_value;
    logic              core_rst_n, ready, fail;
    logic [1:0]        retry_count;
    state_t            dbg_state;

    int total = 0;
    int bad   = 0;
    int psen_cnt = 0;
    int exp_val = 0;
    logic [0:0] exp_q[$];

    dcm_sequencer #(
        .RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(LOCK_TO), .SETTLE_CYCLES(SETTLE),
        .MAX_RETRIES(RETRIES), .PS_LIMIT(LIMIT), .PS_TIMEOUT(PS_TO)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .dcm_locked(dcm_locked), .dcm_status(dcm_status),
        .dcm_psdone(dcm_psdone), .dcm_rst(dcm_rst), .dcm_psen(dcm_psen),
        .dcm_psincdec(dcm_psincdec), .ps_valid(ps_valid), .ps_dir(ps_dir),
        .ps_ready(ps_ready), .ps_value(ps_value), .ps_err(ps_err),
        .core_rst_n(core_rst_n), .ready(ready), .fail(fail),
        .retry_count(retry_count), .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #16 clkin = ~clkin;

    initial begin
        #(32 * 60000);
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check_ps_value(input string tag);
        logic [8:0] e9;
        e9 = exp_val[8:0];
        check(tag, {23'd0, ps_value}, {23'd0, e9});
    endtask

    // Scoreboard: every psen pulse must match the next expected direction.
    always @(negedge clkin) begin
        if (rst_n === 1'b1 && dcm_psen === 1'b1) begin
            psen_cnt++;
            if (exp_q.size() == 0) check("psen_queue_nonempty", 32'(exp_q.size() != 0), 1);
            else check("psincdec", {31'd0, dcm_psincdec}, {31'd0, exp_q.pop_front()});
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_dcm_rst"}, dcm_rst, 1);
        check({tag, "_psen"}, dcm_psen, 0);
        check({tag, "_psincdec"}, dcm_psincdec, 0);
        check({tag, "_ps_ready"}, ps_ready, 0);
        check({tag, "_ps_value"}, {23'd0, ps_value}, 0);
        check({tag, "_ps_err"}, ps_err, 0);
        check({tag, "_core_rst_n"}, core_rst_n, 0);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_retry"}, retry_count, 0);
        check({tag, "_state"}, dbg_state, ST_RESET_DCM);
    endtask

    // DCM model: LOCKED drops while RST is high. Measures RST width.
    task automatic measure_rst_pulse(input string tag);
        int w;
        w = 0;
        dcm_locked = 1'b0;
        while (dcm_rst === 1'b1 && w < RST_CYC + 20) begin
            tick();
            w++;
        end
        check(tag, w, RST_CYC);
    endtask

    task automatic wait_rst_rise(input int bound, output int k);
        k = 0;
        while (dcm_rst !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
    endtask

    // Called right after dcm_rst fell; LOCKED first sampled `delay` edges later.
    task automatic lock_seq(input string tag, input int delay);
        int n;
        bit early;
        n = 0;
        early = 0;
        while (ready !== 1'b1 && n < delay + SETTLE + 50) begin
            tick();
            n++;
            if (n == delay - 1) dcm_locked = 1'b1;
            if (core_rst_n === 1'b1 && ready !== 1'b1) early = 1;
        end
        check({tag, "_lock_to_ready"}, n, delay + 2 + SETTLE);
        check({tag, "_core_rst_n"}, core_rst_n, 1);
        check({tag, "_core_rst_early"}, {31'd0, early}, 0);
        check({tag, "_retry"}, retry_count, 0);
        check({tag, "_ps_ready"}, ps_ready, 1);
    endtask

    // One phase-step request; lat = edges after accept before PSDONE is driven,
    // lat == 0 withholds PSDONE and returns right after the accept edge.
    task automatic step(input bit dir, input int lat);
        int k;
        bit at_lim;
        k = 0;
        while (ps_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check("ps_ready_before_req", ps_ready, 1);
        at_lim = (dir && exp_val == LIMIT) || (!dir && exp_val == -LIMIT);
        if (!at_lim) exp_q.push_back(dir);
        ps_valid = 1'b1;
        ps_dir   = dir;
        tick();
        ps_valid = 1'b0;
        ps_dir   = 1'($urandom_range(0, 1));
        if (at_lim) begin
            check("sat_ps_err", ps_err, 1);
            check("sat_no_psen", dcm_psen, 0);
            check("sat_ps_ready", ps_ready, 1);
            tick();
            check("sat_ps_err_pulse", ps_err, 0);
            check_ps_value("sat_ps_value");
        end else begin
            check("step_psen", dcm_psen, 1);
            check("step_ps_err", ps_err, 0);
            check("step_ps_ready_low", ps_ready, 0);
            if (lat > 0) begin
                for (int i = 1; i <= lat; i++) begin
                    tick();
                    if (i == 1) check("psen_one_cycle", dcm_psen, 0);
                    check("wait_ps_ready_low", ps_ready, 0);
                    check("wait_psincdec_hold", dcm_psincdec, dir);
                end
                dcm_psdone = 1'b1;
                tick();
                dcm_psdone = 1'b0;
                exp_val = dir ? exp_val + 1 : exp_val - 1;
                check_ps_value("step_ps_value");
                check("step_ps_ready_back", ps_ready, 1);
            end
        end
    endtask

    initial begin
        int k;
        int d;
        rst_n = 1'b0;
        dcm_locked = 1'b0;
        dcm_status = 3'b000;
        dcm_psdone = 1'b0;
        ps_valid = 1'b0;
        ps_dir = 1'b0;

        // Reset state.
        repeat (3) tick();
        check_reset_values("reset");

        // Lock path.
        @(negedge clkin);
        rst_n = 1'b1;
        measure_rst_pulse("first_rst_width");
        lock_seq("first", 100);
        check_ps_value("first_ps_value");

        // Directed phase steps: 5 increments, 2 decrements.
        for (int i = 0; i < 5; i++) step(1'b1, 2);
        for (int i = 0; i < 2; i++) step(1'b0, 2);
        check("directed_psen_count", psen_cnt, 7);
        check_ps_value("directed_final_value");
        check("directed_final_is_3", exp_val, 3);
        check("directed_queue_empty", exp_q.size(), 0);

        // Random directions and PSDONE latencies.
        for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));

        // Status bit 0 alone must not disturb RUN.
        dcm_status = 3'b001;
        repeat (6) tick();
        check("ovf_ignored_ready", ready, 1);
        check("ovf_ignored_rst", dcm_rst, 0);
        dcm_status = 3'b000;

        // Saturation at +LIMIT, then a decrement.
        while (exp_val < LIMIT) step(1'b1, 1);
        check_ps_value("sat_reached");
        step(1'b1, 1);
        step(1'b0, 1);
        check("sat_after_dec", {23'd0, ps_value}, 254);

        // Lock loss in RUN.
        dcm_locked = 1'b0;
        wait_rst_rise(10, k);
        check("loss_latency_le3", 32'(k <= 3), 1);
        check("loss_ready", ready, 0);
        check("loss_core_rst_n", core_rst_n, 0);
        exp_val = 0;
        check_ps_value("loss_ps_cleared");
        measure_rst_pulse("loss_rst_width");
        lock_seq("loss_relock", 100);

        // PSDONE withheld.
        step(1'b1, 0);
        wait_rst_rise(PS_TO + 20, k);
        check("psdone_timeout", k, PS_TO);
        exp_val = 0;
        check_ps_value("timeout_ps_cleared");
        check("timeout_ready", ready, 0);
        measure_rst_pulse("timeout_rst_width");
        d = int'($urandom_range(20, 150));
        lock_seq("timeout_relock", d);

        // CLKIN-stopped status in RUN.
        step(1'b0, 3);
        dcm_status = 3'b010;
        wait_rst_rise(10, k);
        check("status_latency_le3", 32'(k <= 3), 1);
        check("status_core_rst_n", core_rst_n, 0);
        dcm_status = 3'b000;
        exp_val = 0;
        check_ps_value("status_ps_cleared");
        measure_rst_pulse("status_rst_width");
        d = int'($urandom_range(20, 150));
        lock_seq("status_relock", d);

        // Asynchronous reset during PS_WAIT.
        step(1'b1, 0);
        repeat (3) tick();
        check("pswait_before_reset", dbg_state, ST_PS_WAIT);
        rst_n = 1'b0;
        dcm_locked = 1'b0;
        #2;
        check_reset_values("midwait_reset");
        exp_val = 0;
        exp_q.delete();

        // Never lock: retries then FAIL.
        @(negedge clkin);
        rst_n = 1'b1;
        measure_rst_pulse("nolock_rst_width0");
        for (int i = 1; i <= RETRIES; i++) begin
            wait_rst_rise(LOCK_TO + 20, k);
            check("nolock_timeout", k, LOCK_TO);
            check("nolock_retry", retry_count, i);
            check("nolock_core_rst_n", core_rst_n, 0);
            if (i < RETRIES) begin
                check("nolock_not_fail", fail, 0);
                measure_rst_pulse("nolock_rst_width");
            end else begin
                check("nolock_fail", fail, 1);
                check("nolock_state", dbg_state, ST_FAIL);
            end
        end
        repeat (50) tick();
        check("fail_sticky", fail, 1);
        check("fail_dcm_rst", dcm_rst, 1);
        check("fail_core_rst_n", core_rst_n, 0);
        check("fail_ready", ready, 0);
        check("fail_retry", retry_count, RETRIES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
